// File: rtl/cla_nibble_serial_adder_if.sv
// Operand/result handshake bundle for cla_nibble_serial_adder.
// The optional `sub` signal exists only when CLA_SERIAL_SUB_EN is defined.
interface cla_nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef CLA_SERIAL_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef CLA_SERIAL_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry-lookahead slice per clock, LSB nibble first.
// Define CLA_SERIAL_SUB_EN to add the `sub` input (a - b via ~b and forced carry-in).
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_nibble_serial_adder_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {cout, sum[3:0]} of a 4-bit carry-lookahead slice.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic [4:0]       nib_s;
    logic [WIDTH+3:0] res_cat_s;
    logic [WIDTH-1:0] res_next_s;

    // Effective B operand and carry-in as seen at the accept edge.
    always_comb begin
        b_eff_s   = bus.b;
        cin_eff_s = bus.cin;
`ifdef CLA_SERIAL_SUB_EN
        if (bus.sub) begin
            b_eff_s   = ~bus.b;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = bus.b;
            cin_eff_s = bus.cin;
        end
`endif
    end

    assign nib_s      = cla4(a_sh_q[3:0], b_sh_q[3:0], carry_q);
    assign res_cat_s  = {nib_s[3:0], res_sh_q};
    assign res_next_s = res_cat_s[WIDTH+3:4];

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        carry_d     = carry_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = b_eff_s;
                    carry_d = cin_eff_s;
                    cnt_d   = '0;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = b_eff_s[WIDTH-1];
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 32'd4;
                b_sh_d   = b_sh_q >> 32'd4;
                res_sh_d = res_next_s;
                carry_d  = nib_s[4];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(NIB - 1)) begin
                    sum_d       = res_next_s;
                    cout_d      = nib_s[4];
                    ovf_d       = (a_msb_q == b_msb_q) && (nib_s[3] != a_msb_q);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            carry_q     <= carry_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
